// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state type and request legality helpers.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} dmem_state_t;

   // Unsigned sizes exist only for loads.
   function automatic logic size_legal(input logic [2:0] funct3, input logic is_store);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      case (funct3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load formatter: picks the addressed byte/half out of a RAM word
// and sign- or zero-extends it to 32 bits.
module dmem_load_align
   import riscv_mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign shifted_s = word_i >> {off_i, 3'b000};
   assign byte_s    = shifted_s[7:0];
   assign half_s    = off_i[1] ? word_i[31:16] : word_i[15:0];

   // Extension by access size
   always_comb begin
      data_o = 32'h0000_0000;
      case (funct3_i)
         F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
         F3_BU:   data_o = {24'h00_0000, byte_s};
         F3_H:    data_o = {{16{half_s[15]}}, half_s};
         F3_HU:   data_o = {16'h0000, half_s};
         F3_W:    data_o = word_i;
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with RISC-V B/H/W stores, fixed-latency loads,
// busy while a load is in flight and a one-cycle err pulse for dropped requests.
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int RD_LAT = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              err
);

   localparam int         DEPTH    = 2**(ADDR_W-2);
   localparam int         WI_W     = ADDR_W-2;
   localparam logic [2:0] CNT_INIT = 3'(RD_LAT-1);

   logic [31:0] mem [DEPTH];

   dmem_state_t       state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [WI_W-1:0]   word_q, word_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              err_q, err_d;

   logic              req_s, accept_s, st_acc_s, ld_acc_s;
   logic [WI_W-1:0]   widx_s;
   logic [3:0]        be_s;
   logic [31:0]       wdata_s, rd_word_s, aligned_s;

   assign req_s    = wr | rd;
   assign widx_s   = addr[ADDR_W-1:2];
   assign accept_s = (state_q == IDLE) & (wr ^ rd) & size_legal(funct3, wr)
                     & ~misaligned(funct3, addr[1:0]);
   assign st_acc_s = accept_s & wr;
   assign ld_acc_s = accept_s & rd;
   assign err_d    = req_s & ~accept_s;

   // Byte lanes and lane-replicated store data
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = wr_data[31:0];
      case (funct3[1:0])
         2'b00: begin
            be_s    = 4'b0001 << addr[1:0];
            wdata_s = {4{wr_data[7:0]}};
         end
         2'b01: begin
            be_s    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_s = {2{wr_data[15:0]}};
         end
         2'b10: begin
            be_s    = 4'b1111;
            wdata_s = wr_data[31:0];
         end
         default: begin
            be_s    = 4'b0000;
            wdata_s = wr_data[31:0];
         end
      endcase
   end

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (st_acc_s && reset) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
            end
         end
      end
   end

   assign rd_word_s = mem[word_q];

   dmem_load_align u_align (
      .word_i   (rd_word_s),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (aligned_s)
   );

   // Load FSM next state: capture on accept, count down, then present data
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      off_d      = off_q;
      f3_d       = f3_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld_acc_s) begin
               state_d = WAIT;
               cnt_d   = CNT_INIT;
               word_d  = widx_s;
               off_d   = addr[1:0];
               f3_d    = funct3;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               rd_data_d  = aligned_s;
               rd_valid_d = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         word_q     <= {WI_W{1'b0}};
         off_q      <= 2'b00;
         f3_q       <= 3'b000;
         rd_data_q  <= {DATA_W{1'b0}};
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = (state_q == WAIT);
   assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model with a pending-load
// countdown, directed scenarios followed by randomized traffic.
module tb_dmem_responder;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr, rd;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  funct3;
   logic [31:0] rd_data;
   logic        rd_valid, busy, err;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mref [512];
   int          pend = 0;
   logic [31:0] pend_val;
   logic [31:0] exp_rd = 32'h0;
   logic        exp_rv, exp_err;

   dmem_responder #(.DATA_W(32), .ADDR_W(9), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr),
      .wr_data(wr_data), .funct3(funct3), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit legal(input logic w, input logic [8:0] a, input logic [2:0] f3);
      bit size_ok;
      size_ok = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return size_ok && ((a % size_of(f3)) == 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [2:0] f3);
      longint v;
      case (f3)
         3'd0: begin v = mref[a]; if (v > 127) v -= 256; end
         3'd4: v = mref[a];
         3'd1: begin v = mref[a] + 256 * mref[a+1]; if (v > 32767) v -= 65536; end
         3'd5: v = mref[a] + 256 * mref[a+1];
         default: v = longint'(mref[a]) + 256 * longint'(mref[a+1])
                      + 65536 * longint'(mref[a+2]) + 16777216 * longint'(mref[a+3]);
      endcase
      return v[31:0];
   endfunction

   // One clock: drive request, advance model, compare all outputs
   task automatic step(input logic w, input logic r, input logic [8:0] a,
                       input logic [2:0] f3, input logic [31:0] d);
      bit was_busy;
      wr = w; rd = r; addr = a; funct3 = f3; wr_data = d;
      @(posedge clk);
      was_busy = (pend > 0);
      exp_rv   = 1'b0;
      exp_err  = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            exp_rv = 1'b1;
            exp_rd = pend_val;
         end
      end
      if (w || r) begin
         if (was_busy || (w && r) || !legal(w, a, f3)) begin
            exp_err = 1'b1;
         end else if (w) begin
            for (int i = 0; i < size_of(f3); i++) mref[a+i] = d[8*i +: 8];
         end else begin
            pend     = RD_LAT;
            pend_val = ref_load(a, f3);
         end
      end
      #1;
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rv});
      chk("busy", {31'b0, busy}, {31'b0, (pend > 0)});
      chk("err", {31'b0, err}, {31'b0, exp_err});
      chk("rd_data", rd_data, exp_rd);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
   endtask

   task automatic load_expect(input string tag, input logic [8:0] a,
                              input logic [2:0] f3, input logic [31:0] expv);
      bit got;
      got = 0;
      step(1'b0, 1'b1, a, f3, 32'h0);
      for (int k = 0; k < 12 && !got; k++) begin
         idle();
         if (rd_valid === 1'b1) begin
            got = 1;
            chk(tag, rd_data, expv);
         end
      end
      if (!got) chk({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   initial begin
      reset = 1'b0; wr = 1'b0; rd = 1'b0; addr = 9'h0; wr_data = 32'h0; funct3 = 3'b0;
      #12;
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_flags", {29'b0, rd_valid, busy, err}, 32'h0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      for (int w = 0; w < 128; w++) step(1'b1, 1'b0, 9'(w * 4), 3'd2, $urandom);

      // 1: word store / load
      step(1'b1, 1'b0, 9'h010, 3'd2, 32'hDEADBEEF);
      load_expect("lw_10", 9'h010, 3'd2, 32'hDEADBEEF);
      // 2: sub-word loads
      load_expect("lb_13",  9'h013, 3'd0, 32'hFFFFFFDE);
      load_expect("lbu_13", 9'h013, 3'd4, 32'h000000DE);
      load_expect("lh_12",  9'h012, 3'd1, 32'hFFFFDEAD);
      load_expect("lhu_12", 9'h012, 3'd5, 32'h0000DEAD);
      // 3: byte store merge
      step(1'b1, 1'b0, 9'h011, 3'd0, 32'h12345655);
      load_expect("sb_merge", 9'h010, 3'd2, 32'hDEAD55EF);
      // 4: dropped requests
      step(1'b0, 1'b1, 9'h011, 3'd1, 32'h0);
      step(1'b1, 1'b0, 9'h012, 3'd2, 32'h11111111);
      step(1'b1, 1'b1, 9'h010, 3'd2, 32'h22222222);
      step(1'b0, 1'b1, 9'h000, 3'd2, 32'h0);
      step(1'b0, 1'b1, 9'h004, 3'd2, 32'h0);
      repeat (RD_LAT) idle();
      step(1'b0, 1'b1, 9'h010, 3'd3, 32'h0);
      step(1'b1, 1'b0, 9'h010, 3'd4, 32'h33333333);
      idle();
      load_expect("ram_kept", 9'h010, 3'd2, 32'hDEAD55EF);
      // 5: back-to-back loads, second issued in the rd_valid cycle
      step(1'b1, 1'b0, 9'h000, 3'd2, 32'hA5A50001);
      step(1'b1, 1'b0, 9'h004, 3'd2, 32'h5A5A0002);
      load_expect("b2b_0", 9'h000, 3'd2, 32'hA5A50001);
      load_expect("b2b_4", 9'h004, 3'd2, 32'h5A5A0002);
      // 6: reset while a load is in flight
      step(1'b0, 1'b1, 9'h010, 3'd2, 32'h0);
      idle();
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_busy", {31'b0, busy}, 32'h0);
      chk("rst_mid_valid", {31'b0, rd_valid}, 32'h0);
      chk("rst_mid_data", rd_data, 32'h0);
      pend = 0; exp_rd = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      repeat (4) idle();
      load_expect("post_rst", 9'h010, 3'd2, 32'hDEAD55EF);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         int          op;
         logic [2:0]  f3;
         logic [8:0]  a;
         op = $urandom_range(0, 9);
         f3 = 3'($urandom_range(0, 7));
         a  = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0) a = 9'(a - (a % size_of(f3)));
         case (op)
            0, 1, 2: idle();
            3, 4, 5: step(1'b0, 1'b1, a, f3, 32'h0);
            6, 7, 8: step(1'b1, 1'b0, a, f3, $urandom);
            default: step(1'b1, 1'b1, a, f3, $urandom);
         endcase
      end
      repeat (RD_LAT + 1) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
